// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: run/pause/stop sequencer with tick prescaler, 4-digit BCD count, target compare and lap-hold display.
// Latency: commands act on the next rising edge; first count DIV edges after RUN entry; all outputs registered except disp/done.
// Backpressure: none; start/stop/lap are level-sampled every edge, stop wins over start and over a coincident tick.
//
// Ports:
//   clk     rising-edge clock
//   clr     synchronous active-low reset (overrides every command)
//   start   start from IDLE, resume from PAUSE, restart from DONE
//   stop    pause from RUN, return to IDLE from PAUSE/DONE
//   lap     toggle display freeze while in RUN or PAUSE
//   target  BCD terminal count, 0x0000 free-runs
//   cnt     live BCD count
//   disp    cnt, or the latched lap value while frozen
//   state   00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//   done    state == DONE
//   ovf     one-cycle pulse after a 9999 -> 0000 wrap
module bcd_timer_ctrl #(
    parameter int DIV = 10
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        stop,
    input  logic        lap,
    input  logic [15:0] target,
    output logic [15:0] cnt,
    output logic [15:0] disp,
    output logic [1:0]  state,
    output logic        done,
    output logic        ovf
);

    // DIV == 1 still needs a 1-bit prescaler; it simply stays at zero.
    localparam int            PW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t          state_q,  state_d;
    logic [PW-1:0]   p_q,      p_d;
    logic [15:0]     cnt_q,    cnt_d;
    logic [15:0]     lap_q,    lap_d;
    logic            frozen_q, frozen_d;
    logic            ovf_q,    ovf_d;

    logic            tick;
    logic [3:0]      is_nine;
    logic [3:0]      dig_en;
    logic [15:0]     cnt_inc;
    logic            wrap;

    // Prescaler terminal count while running: this edge advances the count.
    assign tick = (state_q == S_RUN) && (p_q == P_LAST);

    // Ripple-carry digit enables: digit i steps on a tick when every lower
    // digit is 9. wrap is the carry out of digit 3 (9999 -> 0000).
    always_comb begin
        logic carry;
        is_nine = '0;
        dig_en  = '0;
        cnt_inc = cnt_q;
        carry   = tick;
        for (int i = 0; i < 4; i++) begin
            is_nine[i] = (cnt_q[4*i +: 4] == 4'd9);
            dig_en[i]  = carry;
            carry      = carry & is_nine[i];
            if (dig_en[i]) begin
                cnt_inc[4*i +: 4] = is_nine[i] ? 4'd0 : (cnt_q[4*i +: 4] + 4'd1);
            end
        end
        wrap = carry;
    end

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        lap_d    = lap_q;
        frozen_d = frozen_q;
        ovf_d    = 1'b0;

        // Lap toggles freeze in RUN/PAUSE. On freeze the pre-increment count
        // is captured, since cnt_q is the value present at this edge.
        if (lap && (state_q == S_RUN || state_q == S_PAUSE)) begin
            frozen_d = ~frozen_q;
            if (!frozen_q) begin
                lap_d = cnt_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                p_d   = '0;
                if (start && !stop) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    p_d   = '0;
                    cnt_d = cnt_inc;
                    // A wrap lands on 0000, which can never equal a live
                    // (non-zero) target, so ovf fires on every wrap.
                    ovf_d = wrap;
                    // cnt_inc is always valid BCD, so a target holding a
                    // digit above 9 can never match and the block free-runs.
                    if (target != 16'h0000 && cnt_inc == target) begin
                        state_d = S_DONE;
                    end
                end else begin
                    p_d = p_q + 1'b1;
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    p_d      = '0;
                    frozen_d = 1'b0;
                end else if (start) begin
                    // Resume keeps p, so the next tick is DIV-p cycles away.
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (stop) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    p_d      = '0;
                    frozen_d = 1'b0;
                end else if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    p_d     = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q  <= S_IDLE;
            p_q      <= '0;
            cnt_q    <= '0;
            lap_q    <= '0;
            frozen_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            lap_q    <= lap_d;
            frozen_q <= frozen_d;
            ovf_q    <= ovf_d;
        end
    end

    assign cnt   = cnt_q;
    assign state = state_q;
    assign done  = (state_q == S_DONE);
    assign ovf   = ovf_q;
    assign disp  = frozen_q ? lap_q : cnt_q;

    // Structural invariants: the count stays BCD and the prescaler in range.
    a_cnt_bcd: assert property (@(posedge clk) disable iff (!clr)
        (cnt_q[3:0] <= 4'd9) && (cnt_q[7:4] <= 4'd9) &&
        (cnt_q[11:8] <= 4'd9) && (cnt_q[15:12] <= 4'd9));
    a_p_range: assert property (@(posedge clk) disable iff (!clr) p_q <= P_LAST);

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// tb_bcd_timer_ctrl: three bcd_timer_ctrl instances (DIV=1,2,4) driven in parallel, checked against an integer-count model.
// Latency: inputs change 1ns after a rising edge; outputs sampled 1ns after the edge.
// Backpressure: none; every wait on the DUT is cycle-bounded and a timeout counts as a failure.
module tb_bcd_timer_ctrl;

    localparam int ST_IDLE  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_PAUSE = 2;
    localparam int ST_DONE  = 3;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        lap = 1'b0;
    logic [15:0] target = 16'h0000;

    logic [15:0] cnt_o   [3];
    logic [15:0] disp_o  [3];
    logic [1:0]  state_o [3];
    logic        done_o  [3];
    logic        ovf_o   [3];

    int errors = 0;
    int checks = 0;

    // Reference model: count held as a plain integer 0..9999.
    int          divs   [3] = '{1, 2, 4};
    int          m_st   [3] = '{0, 0, 0};
    int          m_n    [3] = '{0, 0, 0};
    int          m_p    [3] = '{0, 0, 0};
    bit          m_frz  [3] = '{0, 0, 0};
    logic [15:0] m_lapv [3] = '{16'h0, 16'h0, 16'h0};
    bit          m_ovf  [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    bcd_timer_ctrl #(.DIV(1)) u_d1 (.clk(clk), .clr(clr), .start(start), .stop(stop), .lap(lap),
        .target(target), .cnt(cnt_o[0]), .disp(disp_o[0]), .state(state_o[0]), .done(done_o[0]), .ovf(ovf_o[0]));
    bcd_timer_ctrl #(.DIV(2)) u_d2 (.clk(clk), .clr(clr), .start(start), .stop(stop), .lap(lap),
        .target(target), .cnt(cnt_o[1]), .disp(disp_o[1]), .state(state_o[1]), .done(done_o[1]), .ovf(ovf_o[1]));
    bcd_timer_ctrl #(.DIV(4)) u_d4 (.clk(clk), .clr(clr), .start(start), .stop(stop), .lap(lap),
        .target(target), .cnt(cnt_o[2]), .disp(disp_o[2]), .state(state_o[2]), .done(done_o[2]), .ovf(ovf_o[2]));

    function automatic logic [15:0] to_bcd(int n);
        logic [15:0] r;
        r[15:12] = 4'((n / 1000) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[3:0]   = 4'(n % 10);
        return r;
    endfunction

    // Integer value of a BCD word, or -1 when any digit is above 9.
    function automatic int bcd_val(logic [15:0] t);
        int v;
        v = 0;
        for (int j = 3; j >= 0; j--) begin
            if (t[4*j +: 4] > 4'd9) return -1;
            v = v * 10 + int'(t[4*j +: 4]);
        end
        return v;
    endfunction

    function automatic logic [15:0] exp_disp(int k);
        return m_frz[k] ? m_lapv[k] : to_bcd(m_n[k]);
    endfunction

    task automatic model_step();
        int tv;
        tv = bcd_val(target);
        for (int k = 0; k < 3; k++) begin
            if (!clr) begin
                m_st[k] = ST_IDLE; m_n[k] = 0; m_p[k] = 0;
                m_frz[k] = 0; m_lapv[k] = 16'h0; m_ovf[k] = 0;
            end else begin
                m_ovf[k] = 0;
                if (lap && (m_st[k] == ST_RUN || m_st[k] == ST_PAUSE)) begin
                    if (!m_frz[k]) m_lapv[k] = to_bcd(m_n[k]);
                    m_frz[k] = !m_frz[k];
                end
                case (m_st[k])
                    ST_IDLE: if (start && !stop) begin m_st[k] = ST_RUN; m_p[k] = 0; end
                    ST_RUN: begin
                        if (stop) m_st[k] = ST_PAUSE;
                        else if (m_p[k] + 1 == divs[k]) begin
                            m_p[k] = 0;
                            m_n[k] = (m_n[k] + 1) % 10000;
                            if (m_n[k] == 0) m_ovf[k] = 1;
                            if (tv > 0 && m_n[k] == tv) m_st[k] = ST_DONE;
                        end else m_p[k] = m_p[k] + 1;
                    end
                    ST_PAUSE: begin
                        if (stop) begin m_st[k] = ST_IDLE; m_n[k] = 0; m_p[k] = 0; m_frz[k] = 0; end
                        else if (start) m_st[k] = ST_RUN;
                    end
                    default: begin
                        if (stop) begin m_st[k] = ST_IDLE; m_n[k] = 0; m_p[k] = 0; m_frz[k] = 0; end
                        else if (start) begin m_st[k] = ST_RUN; m_n[k] = 0; m_p[k] = 0; end
                    end
                endcase
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b0; start = 1'b0; stop = 1'b0; lap = 1'b0;
        cycle();
        clr = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b0; start = 1'b1; target = 16'h0000;
        cycle();
        cycle();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (state_o[k] !== 2'b00 || cnt_o[k] !== 16'h0 || disp_o[k] !== 16'h0 || done_o[k] !== 1'b0 || ovf_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_init k=%0d got st=%b cnt=%h disp=%h done=%b ovf=%b exp all zero",
                         k, state_o[k], cnt_o[k], disp_o[k], done_o[k], ovf_o[k]);
            end
        end
        clr = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 200 && cnt_o[0] !== 16'h0042; i++) cycle();
        checks++;
        if (cnt_o[0] !== 16'h0042) begin
            errors++;
            $display("FAIL reset_wait42 got cnt=%h exp 0042", cnt_o[0]);
        end
        clr = 1'b0;
        cycle();
        clr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (state_o[k] !== 2'b00 || cnt_o[k] !== 16'h0 || disp_o[k] !== 16'h0 || done_o[k] !== 1'b0 || ovf_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_midrun k=%0d got st=%b cnt=%h disp=%h done=%b ovf=%b exp all zero",
                         k, state_o[k], cnt_o[k], disp_o[k], done_o[k], ovf_o[k]);
            end
        end
    endtask

    task automatic test_target_hit();
        do_reset();
        target = 16'h0012;
        pulse_start();
        for (int e = 1; e <= 44; e++) begin
            cycle();
            if (e == 23) begin
                checks++;
                if (cnt_o[1] !== 16'h0011 || state_o[1] !== 2'b01) begin
                    errors++;
                    $display("FAIL target_pre e=%0d got cnt=%h st=%b exp 0011/01", e, cnt_o[1], state_o[1]);
                end
            end else if (e == 24) begin
                checks++;
                if (cnt_o[1] !== 16'h0012 || state_o[1] !== 2'b11 || done_o[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL target_hit got cnt=%h st=%b done=%b exp 0012/11/1", cnt_o[1], state_o[1], done_o[1]);
                end
            end else if (e > 24) begin
                checks++;
                if (cnt_o[1] !== 16'h0012 || state_o[1] !== 2'b11) begin
                    errors++;
                    $display("FAIL target_hold e=%0d got cnt=%h st=%b exp 0012/11", e, cnt_o[1], state_o[1]);
                end
            end
        end
        pulse_start();
        checks++;
        if (cnt_o[1] !== 16'h0000 || state_o[1] !== 2'b01 || done_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL target_restart got cnt=%h st=%b done=%b exp 0000/01/0", cnt_o[1], state_o[1], done_o[1]);
        end
    endtask

    task automatic test_pause_resume();
        do_reset();
        target = 16'h0000;
        pulse_start();
        for (int i = 0; i < 100 && !(m_n[2] == 5 && m_p[2] == 2); i++) cycle();
        checks++;
        if (cnt_o[2] !== 16'h0005) begin
            errors++;
            $display("FAIL pause_wait got cnt=%h exp 0005", cnt_o[2]);
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        for (int i = 0; i < 30; i++) begin
            checks++;
            if (state_o[2] !== 2'b10 || cnt_o[2] !== 16'h0005) begin
                errors++;
                $display("FAIL pause_hold i=%0d got st=%b cnt=%h exp 10/0005", i, state_o[2], cnt_o[2]);
            end
            cycle();
        end
        pulse_start();
        checks++;
        if (state_o[2] !== 2'b01 || cnt_o[2] !== 16'h0005) begin
            errors++;
            $display("FAIL resume_entry got st=%b cnt=%h exp 01/0005", state_o[2], cnt_o[2]);
        end
        cycle();
        checks++;
        if (cnt_o[2] !== 16'h0005) begin
            errors++;
            $display("FAIL resume_early got cnt=%h exp 0005", cnt_o[2]);
        end
        cycle();
        checks++;
        if (cnt_o[2] !== 16'h0006) begin
            errors++;
            $display("FAIL resume_tick got cnt=%h exp 0006", cnt_o[2]);
        end
        stop = 1'b1;
        cycle();
        cycle();
        stop = 1'b0;
        checks++;
        if (state_o[2] !== 2'b00 || cnt_o[2] !== 16'h0000) begin
            errors++;
            $display("FAIL pause_to_idle got st=%b cnt=%h exp 00/0000", state_o[2], cnt_o[2]);
        end
    endtask

    task automatic test_carry_wrap();
        logic [15:0] v;
        int          ovf_cnt;
        ovf_cnt = 0;
        do_reset();
        target = 16'h0000;
        pulse_start();
        for (int e = 1; e <= 10001; e++) begin
            cycle();
            v = cnt_o[0];
            if (ovf_o[0] === 1'b1) ovf_cnt++;
            checks++;
            if (v !== to_bcd(e % 10000) || (v[3:0] > 4'd9) || (v[7:4] > 4'd9) || (v[11:8] > 4'd9) || (v[15:12] > 4'd9)) begin
                errors++;
                $display("FAIL carry_cnt e=%0d got cnt=%h exp %h", e, v, to_bcd(e % 10000));
            end
            checks++;
            if (ovf_o[0] !== (e == 10000)) begin
                errors++;
                $display("FAIL carry_ovf e=%0d got ovf=%b exp %b", e, ovf_o[0], (e == 10000));
            end
        end
        checks++;
        if (ovf_cnt != 1) begin
            errors++;
            $display("FAIL carry_ovf_count got %0d exp 1", ovf_cnt);
        end
    endtask

    task automatic test_lap();
        do_reset();
        target = 16'h0000;
        pulse_start();
        for (int i = 0; i < 100 && cnt_o[0] !== 16'h0007; i++) cycle();
        lap = 1'b1;
        cycle();
        lap = 1'b0;
        checks++;
        if (disp_o[0] !== 16'h0007 || cnt_o[0] !== 16'h0008) begin
            errors++;
            $display("FAIL lap_freeze got disp=%h cnt=%h exp 0007/0008", disp_o[0], cnt_o[0]);
        end
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (disp_o[k] !== exp_disp(k)) begin
                errors++;
                $display("FAIL lap_freeze_model k=%0d got disp=%h exp %h", k, disp_o[k], exp_disp(k));
            end
        end
        cycle(); cycle(); cycle();
        checks++;
        if (disp_o[0] !== 16'h0007 || cnt_o[0] !== 16'h0011) begin
            errors++;
            $display("FAIL lap_hold got disp=%h cnt=%h exp 0007/0011", disp_o[0], cnt_o[0]);
        end
        for (int i = 0; i < 100 && cnt_o[0] !== 16'h0015; i++) cycle();
        lap = 1'b1;
        cycle();
        lap = 1'b0;
        checks++;
        if (disp_o[0] !== 16'h0016 || cnt_o[0] !== 16'h0016) begin
            errors++;
            $display("FAIL lap_release got disp=%h cnt=%h exp 0016/0016", disp_o[0], cnt_o[0]);
        end
        stop = 1'b1;
        cycle();
        cycle();
        stop = 1'b0;
        lap = 1'b1;
        cycle();
        lap = 1'b0;
        checks++;
        if (state_o[0] !== 2'b00 || disp_o[0] !== 16'h0000) begin
            errors++;
            $display("FAIL lap_idle got st=%b disp=%h exp 00/0000", state_o[0], disp_o[0]);
        end
        pulse_start();
        cycle();
        checks++;
        if (disp_o[0] !== 16'h0001) begin
            errors++;
            $display("FAIL lap_idle_after got disp=%h exp 0001", disp_o[0]);
        end
    endtask

    task automatic test_priority();
        logic [15:0] exp_c;
        int          ovf_cnt;
        ovf_cnt = 0;
        do_reset();
        target = 16'h0000;
        start = 1'b1; stop = 1'b1;
        cycle();
        start = 1'b0; stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (state_o[k] !== 2'b00) begin
                errors++;
                $display("FAIL prio_idle k=%0d got st=%b exp 00", k, state_o[k]);
            end
        end
        pulse_start();
        cycle();
        for (int i = 0; i < 10 && m_p[2] != 3; i++) cycle();
        exp_c = to_bcd(m_n[2]);
        start = 1'b1; stop = 1'b1;
        cycle();
        start = 1'b0; stop = 1'b0;
        checks++;
        if (state_o[2] !== 2'b10 || cnt_o[2] !== exp_c) begin
            errors++;
            $display("FAIL prio_tick got st=%b cnt=%h exp 10/%h", state_o[2], cnt_o[2], exp_c);
        end
        do_reset();
        target = 16'h00A0;
        pulse_start();
        for (int e = 1; e <= 10001; e++) begin
            cycle();
            if (ovf_o[0] === 1'b1) ovf_cnt++;
            checks++;
            if (state_o[0] !== 2'b01 || done_o[0] !== 1'b0 || ovf_o[0] !== (e == 10000)) begin
                errors++;
                $display("FAIL prio_badtgt e=%0d got st=%b done=%b ovf=%b exp 01/0/%b",
                         e, state_o[0], done_o[0], ovf_o[0], (e == 10000));
            end
        end
        checks++;
        if (ovf_cnt != 1) begin
            errors++;
            $display("FAIL prio_badtgt_ovf_count got %0d exp 1", ovf_cnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            clr   = ($urandom_range(0, 299) != 0);
            start = ($urandom_range(0, 9) == 0);
            stop  = ($urandom_range(0, 24) == 0);
            lap   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 4))
                    0: target = 16'h0000;
                    1: target = 16'h0003;
                    2: target = 16'h0025;
                    3: target = 16'h00A0;
                    default: target = to_bcd($urandom_range(1, 60));
                endcase
            end
            cycle();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (cnt_o[k] !== to_bcd(m_n[k]) || state_o[k] !== m_st[k][1:0] || disp_o[k] !== exp_disp(k) ||
                    done_o[k] !== (m_st[k] == ST_DONE) || ovf_o[k] !== m_ovf[k]) begin
                    errors++;
                    $display("FAIL random c=%0d k=%0d got cnt=%h st=%b disp=%h done=%b ovf=%b exp cnt=%h st=%0d disp=%h ovf=%b",
                             c, k, cnt_o[k], state_o[k], disp_o[k], done_o[k], ovf_o[k],
                             to_bcd(m_n[k]), m_st[k], exp_disp(k), m_ovf[k]);
                end
            end
        end
        clr = 1'b1; start = 1'b0; stop = 1'b0; lap = 1'b0;
    endtask

    initial begin
        test_reset();
        test_target_hit();
        test_pause_resume();
        test_carry_wrap();
        test_lap();
        test_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_timer_ctrl.md
Name: bcd_timer_ctrl

Overview:
Run/pause/stop controller for a 4-digit cascaded decade-counter chain. It contains a tick prescaler and generates per-digit enables (ripple-carry scheme, digit i steps when digits 0..i-1 are all 9). It compares the BCD count against a programmable target and provides a lap-hold display register. The block is the sequencing front end for stopwatch and countdown-style uses of the decade counter.

Parameters:
DIV, 10, clock cycles per count tick in RUN; legal range >=1; prescaler width = max(1, clog2(DIV)).

Ports:
clk  in  1  clock, all state updates on rising edge
clr  in  1  synchronous active-low reset
start  in  1  level-sampled command: start or resume
stop  in  1  level-sampled command: pause, or clear to idle
lap  in  1  level-sampled command: toggle display freeze
target  in  16  BCD terminal count, digit 3 in [15:12]; 0x0000 = free-run
cnt  out  16  live BCD count
disp  out  16  cnt when not frozen, frozen lap value otherwise
state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
done  out  1  state==DONE
ovf  out  1  one-cycle pulse on 9999->0000 wrap

Behaviour:
- Reset: clk rising edge with clr=0 gives state=IDLE, cnt=0, prescaler p=0, frozen=0, disp=0, done=0, ovf=0. Reset overrides every command and applies mid-operation too.
- All commands are sampled every edge. stop has priority over start and over a tick in the same cycle. lap is independent of start/stop.
- IDLE:
  - cnt=0 and p=0 are held.
  - start=1 and stop=0: go to RUN with p=0.
  - lap is ignored.
- RUN:
  - stop=1: go to PAUSE. p and cnt hold, with no increment that cycle.
  - Otherwise, if p==DIV-1: set p=0 and increment cnt as BCD. Digit 0 rolls 9 to 0 with carry into the next digit.
  - Otherwise: p=p+1.
  - First increment: exactly DIV edges after the edge that entered RUN. Later increments follow every DIV cycles.
  - If target!=0 and the post-increment value equals target, go to DONE on the same edge. cnt holds target.
  - If target==0 and the count wraps 9999 to 0000, ovf=1 for the one cycle after that edge and counting continues.
  - A target with any digit >9 never matches, so the block free-runs without ovf gating changes.
  - A target change during RUN takes effect on the next tick compare. A target already passed is not matched until after wrap.
- PAUSE:
  - cnt and p hold.
  - start=1 and stop=0: return to RUN, continuing from the held p. The next increment is DIV-p cycles later.
  - stop=1: go to IDLE, clearing cnt and p.
- DONE:
  - done=1; cnt and p hold.
  - start=1 and stop=0: restart, setting cnt=0, p=0 and going to RUN.
  - stop=1: go to IDLE.
- Lap:
  - In RUN or PAUSE, lap=1 on an edge toggles frozen.
  - When frozen goes 0 to 1, disp latches the cnt value present at that edge (the pre-increment value if a tick coincides).
  - While frozen=1, disp holds. When frozen=0, disp equals cnt combinationally.
  - Entering IDLE clears frozen.
  - In DONE, lap is ignored and frozen keeps its value.
  - A level held high toggles every cycle; the bench pulses lap for one cycle.
- All outputs are registered except disp, which is a mux of registered values, and done, which is decoded from state.

Test Plan:
1. Reset: clr=0 for 2 edges with start=1 asserted -> state=00, cnt=0x0000, disp=0x0000, done=0, ovf=0. Repeat with clr=0 pulsed mid-RUN at cnt=0x0042 -> all zero on the next edge.
2. Target hit: DIV=2, target=0x0012, 1-cycle start pulse -> cnt steps every 2 cycles, reaches 0x0012 at edge 24 after RUN entry with state=11 and done=1 on that edge, cnt held for 20 further cycles. Then start -> cnt=0, RUN.
3. Pause/resume: DIV=4, target=0. Stop when cnt=0x0005 and p=2 -> state=10, cnt and p frozen for 30 cycles. Start -> next increment to 0x0006 exactly 2 cycles later. Stop pulses in PAUSE -> IDLE, cnt=0.
4. Carry/wrap: DIV=1, target=0 -> verify 0x0009->0x0010, 0x0099->0x0100, 0x0999->0x1000, and 0x9999->0x0000 at cycle 10000 with ovf high for exactly 1 cycle. No non-BCD nibble ever appears.
5. Lap: DIV=1, lap pulse at cnt=0x0007 -> disp=0x0007 while cnt keeps counting. Second lap pulse at cnt=0x0015 -> disp equals cnt from that cycle. Lap in IDLE -> no effect.
6. Priority: start=stop=1 in IDLE -> stays IDLE. The same pair in RUN on a tick cycle -> PAUSE with no increment. Target=0x00A0 -> never DONE, wraps with ovf.
